rr_sel_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 40-line select-decoded resource among 40 requesters.

---
 rtl/rr_sel_arbiter.sv | 108 ++++++++++
 tb/tb_rr_sel_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter that owns the select input of a 16->40 select decoder.
// The owner finish strobe is named grant_release because "release" is a reserved word.
module rr_sel_arbiter #(
    parameter int N_REQ    = 40,
    parameter int SEL_W    = 16,
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_release,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_sel,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             timeout,
    output logic             busy
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W:0] N_REQ_W = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [7:0] MAX_HOLD_W = 8'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               win_found;
    logic [IDX_W-1:0]   win_off;
    logic [IDX_W:0]     win_sum;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   owner;
    logic               own_req;
    logic               hold_done;
    logic               grant_end;

    // Rotate requests so bit 0 is the requester at ptr, pick the lowest set bit,
    // then rotate the offset back into an absolute index.
    always_comb begin
        req_dbl   = {req, req} >> ptr;
        req_rot   = req_dbl[N_REQ-1:0];
        win_found = 1'b0;
        win_off   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_off   = IDX_W'(i);
            end
        end
        win_sum = {1'b0, ptr} + {1'b0, win_off};
        if (win_sum >= N_REQ_W) begin
            win_sum = win_sum - N_REQ_W;
        end
        win_idx = win_sum[IDX_W-1:0];
    end

    assign owner     = grant_sel[IDX_W-1:0];
    assign own_req   = |(req & grant_onehot);
    assign hold_done = (hold_cnt == MAX_HOLD_W);
    assign grant_end = grant_release | ~own_req | hold_done;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            hold_cnt     <= '0;
            grant_valid  <= 1'b0;
            grant_sel    <= '0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state        <= GRANT;
                        grant_valid  <= 1'b1;
                        grant_sel    <= SEL_W'(win_idx);
                        grant_onehot <= N_REQ'(1) << win_idx;
                        hold_cnt     <= 8'd1;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        state        <= GAP;
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                        ptr          <= (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
                        // Timeout only when the hold limit is the sole reason for ending.
                        timeout      <= hold_done & own_req & ~grant_release;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed bench for rr_sel_arbiter: a vector table stepped one clock per row,
// plus hand-written hold-limit sequences.
module tb_rr_sel_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] req = '0;
    logic        grant_release = 1'b0;
    logic        grant_valid;
    logic [15:0] grant_sel;
    logic [39:0] grant_onehot;
    logic        timeout;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    rr_sel_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_release(grant_release),
        .grant_valid  (grant_valid),
        .grant_sel    (grant_sel),
        .grant_onehot (grant_onehot),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rel;
        logic [39:0] req;
        logic        valid;
        logic [15:0] sel;
        logic        tmo;
        logic        busy;
        logic        chk_sel;
        logic        chk_ptr;
        logic [5:0]  ptr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [39:0] B0    = 40'h00_0000_0001;
    localparam logic [39:0] B01   = 40'h00_0000_0003;
    localparam logic [39:0] B5    = 40'h00_0000_0020;
    localparam logic [39:0] B7    = 40'h00_0000_0080;
    localparam logic [39:0] B3_20 = 40'h00_0010_0008;
    localparam logic [39:0] B39   = 40'h80_0000_0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic valid, input logic [15:0] sel,
                             input logic tmo, input logic bsy, input logic chk_sel);
        logic [39:0] exp_oh;
        exp_oh = valid ? (40'h1 << sel) : 40'h0;
        check({tag, " valid"}, 40'(grant_valid), 40'(valid));
        check({tag, " onehot"}, grant_onehot, exp_oh);
        check({tag, " timeout"}, 40'(timeout), 40'(tmo));
        check({tag, " busy"}, 40'(busy), 40'(bsy));
        if (chk_sel) check({tag, " sel"}, 40'(grant_sel), 40'(sel));
    endtask

    initial begin
        // rst rel req        valid sel tmo busy chk_sel chk_ptr ptr
        vecs.push_back('{1, 0, '0,    0, 16'd0,  0, 0, 1, 1, 6'd0});
        vecs.push_back('{0, 0, B0,    1, 16'd0,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, B0,    0, 16'd0,  0, 1, 1, 1, 6'd1});
        vecs.push_back('{0, 0, '0,    0, 16'd0,  0, 0, 0, 1, 6'd1});
        vecs.push_back('{0, 0, B3_20, 1, 16'd3,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, B3_20, 0, 16'd3,  0, 1, 1, 1, 6'd4});
        vecs.push_back('{0, 0, B3_20, 0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 0, B3_20, 1, 16'd20, 0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, B3_20, 0, 16'd20, 0, 1, 1, 1, 6'd21});
        vecs.push_back('{0, 0, B3_20, 0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 0, B3_20, 1, 16'd3,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, B3_20, 0, 16'd3,  0, 1, 1, 1, 6'd4});
        vecs.push_back('{0, 0, B3_20, 0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 0, B3_20, 1, 16'd20, 0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, B3_20, 0, 16'd20, 0, 1, 1, 1, 6'd21});
        vecs.push_back('{0, 0, '0,    0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 0, B39,   1, 16'd39, 0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, B0,    0, 16'd39, 0, 1, 1, 1, 6'd0});
        vecs.push_back('{0, 0, B0,    0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 0, B0,    1, 16'd0,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, B0,    0, 16'd0,  0, 1, 1, 1, 6'd1});
        vecs.push_back('{0, 0, '0,    0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 0, B7,    1, 16'd7,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 0, B7,    1, 16'd7,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 0, '0,    0, 16'd7,  0, 1, 1, 1, 6'd8});
        vecs.push_back('{0, 0, '0,    0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 0, B7,    1, 16'd7,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{1, 0, B7,    0, 16'd0,  0, 0, 1, 1, 6'd0});
        vecs.push_back('{0, 0, B01,   1, 16'd0,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, B01,   0, 16'd0,  0, 1, 1, 1, 6'd1});
        vecs.push_back('{0, 0, B01,   0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 0, B01,   1, 16'd1,  0, 1, 1, 0, 6'd0});
        vecs.push_back('{0, 1, '0,    0, 16'd1,  0, 1, 1, 1, 6'd2});
        vecs.push_back('{0, 1, '0,    0, 16'd0,  0, 0, 0, 0, 6'd0});
        vecs.push_back('{0, 1, '0,    0, 16'd0,  0, 0, 0, 1, 6'd2});

        for (int i = 0; i < vecs.size(); i++) begin
            rst           = vecs[i].rst;
            grant_release = vecs[i].rel;
            req           = vecs[i].req;
            step();
            check_out($sformatf("row%0d", i), vecs[i].valid, vecs[i].sel, vecs[i].tmo,
                      vecs[i].busy, vecs[i].chk_sel);
            if (vecs[i].chk_ptr) check($sformatf("row%0d ptr", i), 40'(dut.ptr), 40'(vecs[i].ptr));
        end

        // Hold limit: requester 5 keeps asking and never releases.
        rst = 1'b0;
        grant_release = 1'b0;
        req = B5;
        for (int k = 0; k < 15; k++) begin
            step();
            check_out($sformatf("hold%0d", k), 1'b1, 16'd5, 1'b0, 1'b1, 1'b1);
        end
        step();
        check_out("timeout_end", 1'b0, 16'd5, 1'b1, 1'b1, 1'b1);
        check("timeout_end ptr", 40'(dut.ptr), 40'd6);
        step();
        check_out("timeout_gap", 1'b0, 16'd5, 1'b0, 1'b0, 1'b1);
        step();
        check_out("regrant", 1'b1, 16'd5, 1'b0, 1'b1, 1'b1);

        // Release on the last allowed cycle suppresses the timeout pulse.
        for (int k = 0; k < 14; k++) begin
            step();
            check_out($sformatf("rehold%0d", k), 1'b1, 16'd5, 1'b0, 1'b1, 1'b1);
        end
        grant_release = 1'b1;
        step();
        check_out("release_at_limit", 1'b0, 16'd5, 1'b0, 1'b1, 1'b1);
        grant_release = 1'b0;
        req = '0;
        step();
        check_out("final_idle", 1'b0, 16'd5, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
